// File: rtl/scan_chain_ctrl_pkg.sv
// Shared definitions for the scan chain sequencer: FSM state encoding,
// default geometry and the counter width helper.
package scan_chain_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SHIFT_OUT = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam int N_DEF   = 8;
  localparam int CAP_DEF = 1;

  // One counter serves every timed state, so it must hold the longest count.
  function automatic int cnt_width(input int n, input int cap);
    return $clog2(((n > cap) ? n : cap) + 1);
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host/chain-facing signal bundle of the scan sequencer. The slave modport
// is the sequencer's view; the master modport is the host plus chain side.
interface scan_chain_ctrl_if
  import scan_chain_ctrl_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic         start;
  logic [N-1:0] pattern;
  logic         SO;
  logic         ready;
  logic         SE;
  logic         SD;
  logic [N-1:0] response;
  logic         done;

  modport slave (
    input  start,
    input  pattern,
    input  SO,
    output ready,
    output SE,
    output SD,
    output response,
    output done
  );

  modport master (
    output start,
    output pattern,
    output SO,
    input  ready,
    input  SE,
    input  SD,
    input  response,
    input  done
  );

endinterface

// File: rtl/scan_chain_ctrl_shreg.sv
// W-bit shift register: parallel load, shift toward the MSB with serial
// input at the LSB, MSB available as serial output. Load beats shift.
module scan_chain_ctrl_shreg
  import scan_chain_ctrl_pkg::*;
#(
  parameter int W = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] par_o,
  output logic         ser_o
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  // Next value: parallel load, else shift left, else hold.
  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = load_val_i;
    end else if (shift_i) begin
      sh_d = {sh_q[W-2:0], ser_i};
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign par_o = sh_q;
  assign ser_o = sh_q[W-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a parallel pattern into the chain MSB first,
// runs CAP_CYCLES functional capture cycles, then shifts the response out
// into a parallel register and pulses done.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready, chain not driven (SE=0, SD=0), waits for start
// SHIFT_IN   | N cycles, SE=1, SD = pattern MSB, pattern register shifts
// CAPTURE    | CAP_CYCLES cycles, SE=0, chain loads functional D
// SHIFT_OUT  | N cycles, SE=1, SD=0, SO shifted into the response register
// DONE       | one cycle, done=1, response valid
module scan_chain_ctrl
  import scan_chain_ctrl_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int CAP_CYCLES = CAP_DEF
) (
  input logic              clk,
  input logic              reset,
  scan_chain_ctrl_if.slave bus
);

  localparam int CW = cnt_width(N, CAP_CYCLES);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(CAP_CYCLES - 1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic         pat_load;
  logic         pat_shift;
  logic         pat_msb;
  logic         rsp_shift;
  logic [N-1:0] rsp_par;

  // Only the MSB of the pattern register and only the parallel view of the
  // response register are needed; the other views are intentionally unused.
  logic [N-1:0] pat_par_unused;
  logic         rsp_ser_unused;

  scan_chain_ctrl_shreg #(.W(N)) u_pat_shreg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pat_load),
    .load_val_i (bus.pattern),
    .shift_i    (pat_shift),
    .ser_i      (1'b0),
    .par_o      (pat_par_unused),
    .ser_o      (pat_msb)
  );

  scan_chain_ctrl_shreg #(.W(N)) u_rsp_shreg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (rsp_shift),
    .ser_i      (bus.SO),
    .par_o      (rsp_par),
    .ser_o      (rsp_ser_unused)
  );

  // State and counter registers; reset returns to IDLE with no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and shift-register control, plus output decode.
  // Outputs depend on state_q and registers only, never on inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_load  = 1'b0;
    pat_shift = 1'b0;
    rsp_shift = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          pat_load = 1'b1;
          state_d  = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        pat_shift = 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == CAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT_OUT: begin
        rsp_shift = 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    bus.ready    = (state_q == ST_IDLE);
    bus.SE       = (state_q == ST_SHIFT_IN) || (state_q == ST_SHIFT_OUT);
    bus.SD       = (state_q == ST_SHIFT_IN) && pat_msb;
    bus.done     = (state_q == ST_DONE);
    bus.response = rsp_par;
  end

endmodule
